add_seq_mult: RTL



---
 rtl/add_seq_mult_pkg.sv | 5 +
 rtl/add_seq_mult_fsm.sv | 52 +++++
 rtl/add_seq_mult.sv | 70 +++++++
 3 files changed

// File: rtl/add_seq_mult_pkg.sv
// add_seq_mult_pkg: shared state encoding and default width for the sequenced multiplier
package add_seq_mult_pkg;
    localparam int WIDTH_DEF = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/add_seq_mult_fsm.sv
// add_seq_mult_fsm: IDLE/ADD/DONE sequencer producing register enables and busy/done
// Ports: clk, rst (sync, active-high), start (accepted only in IDLE), cnt_zero (iteration count exhausted)
//        state (registered state), load_en (capture operands), add_en (accumulate step), busy, done
module add_seq_mult_fsm
    import add_seq_mult_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cnt_zero,
    output logic [1:0] state,
    output logic       load_en,
    output logic       add_en,
    output logic       busy,
    output logic       done
);
    state_t r_state;
    logic   r_busy;
    logic   r_done;

    // busy/done are registered alongside the state so they mirror it without decode glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state <= ADD;
                    r_busy  <= 1'b1;
                end
                ADD: if (cnt_zero) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign state   = r_state;
    assign load_en = (r_state == IDLE) && start;
    assign add_en  = (r_state == ADD) && !cnt_zero;
    assign busy    = r_busy;
    assign done    = r_done;
endmodule

// File: rtl/add_seq_mult.sv
// add_seq_mult: multiplies a by b through b repeated additions of a into an accumulator
// Ports: clk, rst (sync, active-high), start (request), a/b (operands captured on accepted start)
//        busy (adding), done (one-cycle completion pulse), product (accumulator), ovf (sticky carry-out)
module add_seq_mult
    import add_seq_mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             ovf
);
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic [1:0]       w_state;
    logic             w_load_en;
    logic             w_add_en;
    logic             w_cnt_zero;
    logic [WIDTH:0]   w_sum;

    assign w_cnt_zero = (r_cnt == '0);
    // extra top bit of the sum is the carry-out that feeds the sticky overflow
    assign w_sum      = {1'b0, r_acc} + {1'b0, r_op_a};

    add_seq_mult_fsm u_fsm (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cnt_zero (w_cnt_zero),
        .state    (w_state),
        .load_en  (w_load_en),
        .add_en   (w_add_en),
        .busy     (busy),
        .done     (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a <= '0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
        end else if (w_load_en) begin
            r_op_a <= a;
            r_cnt  <= b;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
        end else if (w_add_en) begin
            r_acc  <= w_sum[WIDTH-1:0];
            r_ovf  <= r_ovf | w_sum[WIDTH];
            r_cnt  <= r_cnt - WIDTH'(1);
        end
    end

    // the unused 2'b11 encoding must never be reached and busy/done are exclusive
    always_ff @(posedge clk) begin
        if (!rst) assert (w_state != 2'b11 && !(busy && done));
    end

    assign product = r_acc;
    assign ovf     = r_ovf;
endmodule
